// File: rtl/fir_interp_iq_if.sv
// Sample, coefficient and status bundle of the TX interpolate-by-2 FIR.
// The master side is the sample source/configuration agent; the slave side is the filter.
interface fir_interp_iq_if #(
    parameter int WIDTH = 24,
    parameter int COEFF = 18,
    parameter int NTAPS = 33
);
    localparam int H  = (NTAPS + 1) / 2;
    localparam int CW = $clog2(H);

    logic                    in_strobe;
    logic signed [WIDTH-1:0] in_data_i;
    logic signed [WIDTH-1:0] in_data_q;
    logic                    coef_wr;
    logic [CW-1:0]           coef_addr;
    logic signed [COEFF-1:0] coef_data;
    logic                    out_strobe;
    logic signed [WIDTH-1:0] out_data_i;
    logic signed [WIDTH-1:0] out_data_q;
    logic                    busy;
    logic                    overrun;

    modport master (
        output in_strobe, in_data_i, in_data_q, coef_wr, coef_addr, coef_data,
        input  out_strobe, out_data_i, out_data_q, busy, overrun
    );

    modport slave (
        input  in_strobe, in_data_i, in_data_q, coef_wr, coef_addr, coef_data,
        output out_strobe, out_data_i, out_data_q, busy, overrun
    );
endinterface

// File: rtl/fir_interp_iq.sv
// Interpolate-by-2 symmetric polyphase FIR for I/Q, one shared MAC per rail.
// state | meaning
// IDLE  | waiting for in_strobe; history shifts on accept
// LATCH | clear accumulators, load tap down-counter for phase A
// MAC_A | acc += buf[j]*h[2j], j = H-1 .. 0
// OUT_A | phase-A sample on the outputs, reload counter for phase B
// MAC_B | acc += buf[j]*h[2j+1], j = H-2 .. 0
// OUT_B | phase-B sample on the outputs
module fir_interp_iq #(
    parameter int WIDTH = 24,
    parameter int COEFF = 18,
    parameter int NTAPS = 33
) (
    input logic            adc_clk,
    input logic            reset,
    fir_interp_iq_if.slave bus
);
    localparam int H  = (NTAPS + 1) / 2;
    localparam int CW = $clog2(H);
    localparam int KW = $clog2(NTAPS) + 1;
    localparam int PW = WIDTH + COEFF;
    localparam int AW = WIDTH + COEFF + CW;

    typedef enum logic [2:0] {IDLE, LATCH, MAC_A, OUT_A, MAC_B, OUT_B} state_t;

    state_t                  state_q;
    logic signed [WIDTH-1:0] buf_i_q [H];
    logic signed [WIDTH-1:0] buf_q_q [H];
    logic signed [COEFF-1:0] coef_q  [H];
    logic signed [AW-1:0]    acc_i_q, acc_q_q;
    logic [CW-1:0]           cnt_q;
    logic                    out_strobe_q, busy_q, overrun_q;
    logic signed [WIDTH-1:0] out_i_q, out_q_q;

    logic [KW-1:0]           tap_k, tap_kr, tap_idx;
    logic signed [PW-1:0]    prod_i, prod_q;
    logic signed [AW-1:0]    acc_i_d, acc_q_d, shr_i, shr_q;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        if ((&v[AW-1:WIDTH-1]) || !(|v[AW-1:WIDTH-1]))
            return v[WIDTH-1:0];
        else if (v[AW-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // Prototype tap k = 2j (+1 in phase B), folded onto the stored half.
    always_comb begin
        tap_k   = {{(KW-CW-1){1'b0}}, cnt_q, state_q == MAC_B};
        tap_kr  = KW'(NTAPS - 1) - tap_k;
        tap_idx = (tap_k <= tap_kr) ? tap_k : tap_kr;
        prod_i  = PW'(buf_i_q[cnt_q]) * PW'(coef_q[tap_idx]);
        prod_q  = PW'(buf_q_q[cnt_q]) * PW'(coef_q[tap_idx]);
        acc_i_d = acc_i_q + {{(AW-PW){prod_i[PW-1]}}, prod_i};
        acc_q_d = acc_q_q + {{(AW-PW){prod_q[PW-1]}}, prod_q};
        shr_i   = acc_i_d >>> (COEFF - 2);
        shr_q   = acc_q_d >>> (COEFF - 2);
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int k = 0; k < H; k++) begin
                buf_i_q[k] <= '0;
                buf_q_q[k] <= '0;
                coef_q[k]  <= '0;
            end
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            cnt_q        <= '0;
            out_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            out_i_q      <= '0;
            out_q_q      <= '0;
        end else begin
            out_strobe_q <= 1'b0;
            if (bus.coef_wr && ({1'b0, bus.coef_addr} < (CW+1)'(H)))
                coef_q[bus.coef_addr] <= bus.coef_data;
            if (bus.in_strobe && busy_q)
                overrun_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.in_strobe) begin
                        for (int k = H - 1; k > 0; k--) begin
                            buf_i_q[k] <= buf_i_q[k-1];
                            buf_q_q[k] <= buf_q_q[k-1];
                        end
                        buf_i_q[0] <= bus.in_data_i;
                        buf_q_q[0] <= bus.in_data_q;
                        busy_q     <= 1'b1;
                        state_q    <= LATCH;
                    end
                end
                LATCH: begin
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                    cnt_q   <= CW'(H - 1);
                    state_q <= MAC_A;
                end
                MAC_A, MAC_B: begin
                    acc_i_q <= acc_i_d;
                    acc_q_q <= acc_q_d;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        out_i_q      <= sat(shr_i);
                        out_q_q      <= sat(shr_q);
                        out_strobe_q <= 1'b1;
                        state_q      <= (state_q == MAC_A) ? OUT_A : OUT_B;
                    end
                end
                OUT_A: begin
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                    cnt_q   <= CW'(H - 2);
                    state_q <= MAC_B;
                end
                OUT_B: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_strobe = out_strobe_q;
    assign bus.out_data_i = out_i_q;
    assign bus.out_data_q = out_q_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_fir_interp_iq.sv
// Bench for fir_interp_iq: directed impulse tables, random stream against a
// zero-stuffed convolution model, plus latency/overrun and mid-run reset sequences.
module tb_fir_interp_iq;
    localparam int WIDTH = 24;
    localparam int COEFF = 18;
    localparam int NTAPS = 33;
    localparam int H     = (NTAPS + 1) / 2;

    logic adc_clk = 1'b0;
    logic reset;
    always #5 adc_clk = ~adc_clk;

    fir_interp_iq_if #(.WIDTH(WIDTH), .COEFF(COEFF), .NTAPS(NTAPS)) bus ();
    fir_interp_iq #(.WIDTH(WIDTH), .COEFF(COEFF), .NTAPS(NTAPS)) dut (
        .adc_clk(adc_clk),
        .reset  (reset),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: full tap set convolved with the zero-stuffed input stream.
    longint cm [H];
    longint up_i[$], up_q[$];

    function automatic void model_reset();
        for (int k = 0; k < H; k++) cm[k] = 0;
        up_i.delete();
        up_q.delete();
        for (int k = 0; k < NTAPS; k++) begin
            up_i.push_back(0);
            up_q.push_back(0);
        end
    endfunction

    function automatic longint htap(input int k);
        return cm[(k < NTAPS - 1 - k) ? k : NTAPS - 1 - k];
    endfunction

    function automatic longint fir_dot(input longint q[$]);
        longint s = 0;
        for (int k = 0; k < NTAPS; k++) s += htap(k) * q[k];
        s = s >>> (COEFF - 2);
        if (s > 64'sd8388607)  s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        return s;
    endfunction

    task automatic model_step(input longint xi, input longint xq,
                              output longint ai, output longint aq,
                              output longint bi, output longint bq);
        up_i.push_front(xi); void'(up_i.pop_back());
        up_q.push_front(xq); void'(up_q.pop_back());
        ai = fir_dot(up_i);
        aq = fir_dot(up_q);
        up_i.push_front(0); void'(up_i.pop_back());
        up_q.push_front(0); void'(up_q.pop_back());
        bi = fir_dot(up_i);
        bq = fir_dot(up_q);
    endtask

    task automatic do_reset();
        @(negedge adc_clk);
        reset         = 1'b1;
        bus.in_strobe = 1'b0;
        bus.coef_wr   = 1'b0;
        @(negedge adc_clk);
        @(negedge adc_clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int a, input int d);
        logic signed [COEFF-1:0] dv;
        dv = COEFF'(d);
        @(negedge adc_clk);
        bus.coef_wr   = 1'b1;
        bus.coef_addr = $clog2(H)'(a);
        bus.coef_data = dv;
        @(negedge adc_clk);
        bus.coef_wr = 1'b0;
        if (a < H) cm[a] = longint'(dv);
    endtask

    // One input sample; k counts cycles after the accepting edge (k=1 is LATCH).
    task automatic send(input int xi, input int xq, input int dup_at, input int rst_at,
                        output logic signed [WIDTH-1:0] ai, output logic signed [WIDTH-1:0] aq,
                        output logic signed [WIDTH-1:0] bi, output logic signed [WIDTH-1:0] bq,
                        output int ta, output int tb, output int tidle);
        int w = 0;
        int ns = 0;
        while (bus.busy && w < 100) begin
            @(negedge adc_clk);
            w++;
        end
        check("idle_before_send", longint'(bus.busy), 0);
        ai = '0; aq = '0; bi = '0; bq = '0;
        ta = -1; tb = -1; tidle = -1;
        bus.in_data_i = WIDTH'(xi);
        bus.in_data_q = WIDTH'(xq);
        bus.in_strobe = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge adc_clk);
            bus.in_strobe = (k == dup_at);
            reset         = (k == rst_at);
            if (bus.out_strobe) begin
                if (ns == 0) begin
                    ta = k; ai = bus.out_data_i; aq = bus.out_data_q;
                end else begin
                    tb = k; bi = bus.out_data_i; bq = bus.out_data_q;
                end
                ns++;
            end
            if (!bus.busy && tidle < 0) tidle = k;
            if (ns == 2 && tidle >= 0) break;
        end
        bus.in_strobe = 1'b0;
        reset         = 1'b0;
    endtask

    typedef struct {
        bit rst;
        int cidx, cval;
        int xi, xq;
        int ai, aq, bi, bq;
    } vec_t;
    vec_t tbl[$];

    function automatic void add_row(input bit rst, input int cidx, input int cval,
                                    input int xi, input int xq,
                                    input int ai, input int aq, input int bi, input int bq);
        vec_t v;
        v.rst = rst; v.cidx = cidx; v.cval = cval; v.xi = xi; v.xq = xq;
        v.ai = ai; v.aq = aq; v.bi = bi; v.bq = bq;
        tbl.push_back(v);
    endfunction

    initial begin
        logic signed [WIDTH-1:0] ai, aq, bi, bq;
        longint ei, eq, fi, fq;
        int ta, tb, tidle;
        int xi, xq;

        reset         = 1'b1;
        bus.in_strobe = 1'b0;
        bus.in_data_i = '0;
        bus.in_data_q = '0;
        bus.coef_wr   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        do_reset();

        check("rst_out_strobe", longint'(bus.out_strobe), 0);
        check("rst_out_i", longint'(bus.out_data_i), 0);
        check("rst_out_q", longint'(bus.out_data_q), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_overrun", longint'(bus.overrun), 0);

        // Centre tap, symmetric end taps, odd phase, saturation.
        for (int n = 1; n <= 10; n++)
            add_row(n == 1, 16, 'h10000, (n == 1) ? 1000 : 0, (n == 1) ? -1000 : 0,
                    (n == 9) ? 1000 : 0, (n == 9) ? -1000 : 0, 0, 0);
        for (int n = 1; n <= 17; n++)
            add_row(n == 1, 0, 'h10000, (n == 1) ? 500 : 0, 0,
                    (n == 1 || n == 17) ? 500 : 0, 0, 0, 0);
        for (int n = 1; n <= 9; n++)
            add_row(n == 1, 15, 'h10000, (n == 1) ? 500 : 0, 0,
                    0, 0, (n == 8 || n == 9) ? 500 : 0, 0);
        for (int n = 1; n <= 9; n++)
            add_row(n == 1, 16, 'h1FFFF, (n == 1) ? 8388607 : 0, (n == 1) ? -8388608 : 0,
                    (n == 9) ? 8388607 : 0, (n == 9) ? -8388608 : 0, 0, 0);

        foreach (tbl[r]) begin
            if (tbl[r].rst) begin
                do_reset();
                write_coef(tbl[r].cidx, tbl[r].cval);
            end
            send(tbl[r].xi, tbl[r].xq, 0, 0, ai, aq, bi, bq, ta, tb, tidle);
            check($sformatf("tbl%0d_lat_a", r), ta, 19);
            check($sformatf("tbl%0d_lat_b", r), tb, 36);
            check($sformatf("tbl%0d_a_i", r), ai, tbl[r].ai);
            check($sformatf("tbl%0d_a_q", r), aq, tbl[r].aq);
            check($sformatf("tbl%0d_b_i", r), bi, tbl[r].bi);
            check($sformatf("tbl%0d_b_q", r), bq, tbl[r].bq);
        end

        // Random taps and samples; one sample carries a dropped second strobe.
        do_reset();
        for (int a = 0; a < H; a++)
            write_coef(a, int'($urandom_range(0, 80000)) - 40000);
        write_coef(int'($urandom_range(H, 31)), 'h1ABCD);
        for (int n = 0; n < 30; n++) begin
            if (n % 5 == 4) begin
                xi = int'($urandom_range(0, 16777215)) - 8388608;
                xq = int'($urandom_range(0, 16777215)) - 8388608;
            end else begin
                xi = int'($urandom_range(0, 400000)) - 200000;
                xq = int'($urandom_range(0, 400000)) - 200000;
            end
            send(xi, xq, (n == 12) ? 10 : 0, 0, ai, aq, bi, bq, ta, tb, tidle);
            model_step(xi, xq, ei, eq, fi, fq);
            check($sformatf("rnd%0d_lat_a", n), ta, 19);
            check($sformatf("rnd%0d_lat_b", n), tb, 36);
            check($sformatf("rnd%0d_a_i", n), ai, ei);
            check($sformatf("rnd%0d_a_q", n), aq, eq);
            check($sformatf("rnd%0d_b_i", n), bi, fi);
            check($sformatf("rnd%0d_b_q", n), bq, fq);
            if (n == 0)  check("overrun_clear", longint'(bus.overrun), 0);
            if (n == 12) begin
                check("busy_low_at", tidle, 37);
                check("overrun_set", longint'(bus.overrun), 1);
            end
        end

        // Reset at t+5 with a coincident strobe: no output, everything cleared.
        send(123456, -654321, 5, 5, ai, aq, bi, bq, ta, tb, tidle);
        model_reset();
        check("midrst_no_strobe", ta, -1);
        check("midrst_out_i", longint'(bus.out_data_i), 0);
        check("midrst_out_q", longint'(bus.out_data_q), 0);
        check("midrst_busy", longint'(bus.busy), 0);
        check("midrst_overrun", longint'(bus.overrun), 0);
        send(777777, -333333, 0, 0, ai, aq, bi, bq, ta, tb, tidle);
        check("post_rst_lat_a", ta, 19);
        check("post_rst_a_i", ai, 0);
        check("post_rst_a_q", aq, 0);
        check("post_rst_b_i", bi, 0);
        model_step(777777, -333333, ei, eq, fi, fq);

        write_coef(16, 'h10000);
        for (int n = 0; n < 10; n++) begin
            xi = int'($urandom_range(0, 2000000)) - 1000000;
            xq = int'($urandom_range(0, 2000000)) - 1000000;
            send(xi, xq, 0, 0, ai, aq, bi, bq, ta, tb, tidle);
            model_step(xi, xq, ei, eq, fi, fq);
            check($sformatf("post%0d_a_i", n), ai, ei);
            check($sformatf("post%0d_a_q", n), aq, eq);
            check($sformatf("post%0d_b_i", n), bi, fi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
